// File: rtl/fpdiv_quotient_ctrl_pkg.sv
// Shared fixed-point constants and FSM encoding for the quotient controller.
// Sign-magnitude format: bit N-1 is the sign, the low Q bits are fractional.
package fpdiv_quotient_ctrl_pkg;

  localparam int DEF_Q           = 32;
  localparam int DEF_N           = 48;
  localparam int DEF_TIMEOUT_CYC = 255;

  localparam logic [47:0] NUMBER_ONE        = 48'h0001_0000_0000;
  localparam logic [47:0] NUMBER_TWO        = 48'h0002_0000_0000;
  localparam logic [47:0] NUMBER_POINT_FIVE = 48'h0000_8000_0000;
  localparam logic [47:0] SAT_MAG           = 48'h7FFF_FFFF_FFFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ISSUE,
    S_WAIT,
    S_MUL1,
    S_MUL2,
    S_SIGN,
    S_DONE
  } state_t;

endpackage

// File: rtl/fpdiv_quotient_ctrl_if.sv
// Request/result signals plus the startdiv/in/ans/donediv link to the reciprocal core.
// slave = the controller, master = the requester side (and the core stub in a bench).
interface fpdiv_quotient_ctrl_if
  import fpdiv_quotient_ctrl_pkg::*;
#(
  parameter int N = DEF_N
);
  logic         start;
  logic [N-1:0] num;
  logic [N-1:0] den;
  logic         busy;
  logic         done;
  logic [N-1:0] quot;
  logic         div0;
  logic         tmo;
  logic         div_start;
  logic [N-1:0] div_in;
  logic [N-1:0] div_ans;
  logic         div_done;

  modport slave (
    input  start, num, den, div_ans, div_done,
    output busy, done, quot, div0, tmo, div_start, div_in
  );

  modport master (
    output start, num, den, div_ans, div_done,
    input  busy, done, quot, div0, tmo, div_start, div_in
  );
endinterface

// File: rtl/fpdiv_quotient_ctrl_qmult.sv
// Unsigned Q-format magnitude multiply, truncated to Q fractional bits.
// Integer overflow above the N-1 magnitude bits is silently dropped.
module fpdiv_quotient_ctrl_qmult #(
  parameter int Q = 32,
  parameter int N = 48
) (
  input  logic [N-2:0] a,
  input  logic [N-2:0] b,
  output logic [N-2:0] p
);
  localparam int W = N + Q - 1;

  logic [W-1:0] wide;

  assign wide = W'(a) * W'(b);
  assign p    = (N-1)'(wide >> Q);
endmodule

// File: rtl/fpdiv_quotient_ctrl.sv
// Quotient controller: screens zero operands, fetches 1/|den| from the shared core, scales by |num|.
// Optional WAIT watchdog enabled by defining FPDIV_TIMEOUT_EN.
module fpdiv_quotient_ctrl
  import fpdiv_quotient_ctrl_pkg::*;
#(
  parameter int Q = DEF_Q,
  parameter int N = DEF_N
`ifdef FPDIV_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
`endif
) (
  input logic                 clk,
  input logic                 rst,
  fpdiv_quotient_ctrl_if.slave bus
);

  state_t       state_reg, state_next;
  logic         sign_reg, sign_next;
  logic [N-2:0] num_mag_reg, num_mag_next;
  logic [N-2:0] den_mag_reg, den_mag_next;
  logic [N-2:0] recip_reg, recip_next;
  logic [N-2:0] mul_a_reg, mul_a_next;
  logic [N-2:0] mul_b_reg, mul_b_next;
  logic [N-2:0] prod_reg, prod_next;
  logic [N-1:0] quot_reg, quot_next;
  logic [N-1:0] div_in_reg, div_in_next;
  logic         done_reg, done_next;
  logic         div0_reg, div0_next;
  logic [N-2:0] mul_out;

`ifdef FPDIV_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          tmo_reg, tmo_next;
`endif

  fpdiv_quotient_ctrl_qmult #(.Q(Q), .N(N)) u_qmult (
    .a (mul_a_reg),
    .b (mul_b_reg),
    .p (mul_out)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= S_IDLE;
      sign_reg    <= 1'b0;
      num_mag_reg <= '0;
      den_mag_reg <= '0;
      recip_reg   <= '0;
      mul_a_reg   <= '0;
      mul_b_reg   <= '0;
      prod_reg    <= '0;
      quot_reg    <= '0;
      div_in_reg  <= '0;
      done_reg    <= 1'b0;
      div0_reg    <= 1'b0;
`ifdef FPDIV_TIMEOUT_EN
      cnt_reg     <= '0;
      tmo_reg     <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      sign_reg    <= sign_next;
      num_mag_reg <= num_mag_next;
      den_mag_reg <= den_mag_next;
      recip_reg   <= recip_next;
      mul_a_reg   <= mul_a_next;
      mul_b_reg   <= mul_b_next;
      prod_reg    <= prod_next;
      quot_reg    <= quot_next;
      div_in_reg  <= div_in_next;
      done_reg    <= done_next;
      div0_reg    <= div0_next;
`ifdef FPDIV_TIMEOUT_EN
      cnt_reg     <= cnt_next;
      tmo_reg     <= tmo_next;
`endif
    end
  end

  always_comb begin
    state_next   = state_reg;
    sign_next    = sign_reg;
    num_mag_next = num_mag_reg;
    den_mag_next = den_mag_reg;
    recip_next   = recip_reg;
    mul_a_next   = mul_a_reg;
    mul_b_next   = mul_b_reg;
    prod_next    = prod_reg;
    quot_next    = quot_reg;
    div_in_next  = div_in_reg;
    done_next    = 1'b0;
    div0_next    = div0_reg;
`ifdef FPDIV_TIMEOUT_EN
    cnt_next     = cnt_reg;
    tmo_next     = tmo_reg;
`endif

    case (state_reg)
      S_IDLE: begin
        if (bus.start) begin
          state_next   = S_CHECK;
          sign_next    = bus.num[N-1] ^ bus.den[N-1];
          num_mag_next = bus.num[N-2:0];
          den_mag_next = bus.den[N-2:0];
          div_in_next  = {1'b0, bus.den[N-2:0]};
          div0_next    = 1'b0;
`ifdef FPDIV_TIMEOUT_EN
          tmo_next     = 1'b0;
`endif
        end
      end
      S_CHECK: begin
        // Divide-by-zero saturates with the combined sign; a zero dividend never touches the core.
        if (den_mag_reg == '0) begin
          quot_next  = {sign_reg, {(N-1){1'b1}}};
          div0_next  = 1'b1;
          state_next = S_DONE;
        end else if (num_mag_reg == '0) begin
          quot_next  = '0;
          state_next = S_DONE;
        end else begin
          state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
`ifdef FPDIV_TIMEOUT_EN
        cnt_next   = '0;
`endif
        state_next = S_WAIT;
      end
      S_WAIT: begin
        if (bus.div_done) begin
          recip_next = bus.div_ans[N-2:0];
          state_next = S_MUL1;
        end
`ifdef FPDIV_TIMEOUT_EN
        else if (cnt_reg == CW'(TIMEOUT_CYC - 1)) begin
          quot_next  = '0;
          tmo_next   = 1'b1;
          state_next = S_DONE;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
`endif
      end
      S_MUL1: begin
        mul_a_next = num_mag_reg;
        mul_b_next = recip_reg;
        state_next = S_MUL2;
      end
      S_MUL2: begin
        prod_next  = mul_out;
        state_next = S_SIGN;
      end
      S_SIGN: begin
        // Never emit -0: a product that truncated to zero is reported positive.
        quot_next  = {sign_reg & (prod_reg != '0), prod_reg};
        state_next = S_DONE;
      end
      S_DONE: begin
        done_next  = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign bus.busy      = (state_reg != S_IDLE);
  assign bus.div_start = (state_reg == S_ISSUE);
  assign bus.div_in    = div_in_reg;
  assign bus.done      = done_reg;
  assign bus.quot      = quot_reg;
  assign bus.div0      = div0_reg;
`ifdef FPDIV_TIMEOUT_EN
  assign bus.tmo       = tmo_reg;
`else
  assign bus.tmo       = 1'b0;
`endif

endmodule

// File: tb/tb_fpdiv_quotient_ctrl.sv
// Self-checking bench: reciprocal-core stub, real-division reference model and a result scoreboard.
// Define FPDIV_TIMEOUT_EN to also exercise the WAIT watchdog (TIMEOUT_CYC=16).
module tb_fpdiv_quotient_ctrl;
  import fpdiv_quotient_ctrl_pkg::*;

  localparam int Q   = 32;
  localparam int N   = 48;
  localparam int TOL = 4096;  // 2^-20 in Q32

  typedef struct {
    logic [N-1:0] quot;
    logic         div0;
    logic         tmo;
    bit           approx;
    string        tag;
  } exp_t;

  logic clk;
  logic rst;
  fpdiv_quotient_ctrl_if #(.N(N)) bus ();

`ifdef FPDIV_TIMEOUT_EN
  fpdiv_quotient_ctrl #(.Q(Q), .N(N), .TIMEOUT_CYC(16)) dut (.clk(clk), .rst(rst), .bus(bus));
`else
  fpdiv_quotient_ctrl #(.Q(Q), .N(N)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   done_seen = 0;
  int   done_cyc = 0;
  int   req_cyc = 0;
  int   issue_cyc = 0;
  int   start_cycles = 0;
  bit   core_en = 1'b1;
  int   core_lat = 3;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [N-1:0] n, input logic [N-1:0] d,
                                 input bit tmo_exp, input string tag);
    exp_t         e;
    logic [N-2:0] nm;
    logic [N-2:0] dm;
    logic         s;
    logic [127:0] ex;
    nm = n[N-2:0];
    dm = d[N-2:0];
    s  = n[N-1] ^ d[N-1];
    e.tag = tag; e.div0 = 1'b0; e.tmo = 1'b0; e.approx = 1'b0; e.quot = '0;
    if (tmo_exp) begin
      e.tmo = 1'b1;
    end else if (dm == '0) begin
      e.quot = {s, SAT_MAG[N-2:0]};
      e.div0 = 1'b1;
    end else if (nm != '0) begin
      ex       = ({81'b0, nm} << Q) / {81'b0, dm};
      e.quot   = {s & (ex[N-2:0] != '0), ex[N-2:0]};
      e.approx = 1'b1;
    end
    return e;
  endfunction

  // Reciprocal core stub: answers floor(2^(2Q)/in) core_lat+1 clocks after startdiv.
  initial begin
    bit           pend;
    int           cd;
    logic [N-1:0] ans;
    logic [N-1:0] din_lat;
    logic [127:0] one;
    pend = 1'b0; cd = 0; ans = '0; din_lat = '0;
    one = 128'h1 << (2 * Q);
    bus.div_done = 1'b0;
    bus.div_ans  = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.div_done = 1'b0;
      if (!rst) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          if (cd == 0) begin
            bus.div_done = 1'b1;
            bus.div_ans  = ans;
            pend = 1'b0;
            chk_eq("div_in_stable", 64'(bus.div_in), 64'(din_lat));
          end else begin
            cd--;
          end
        end
        if (bus.div_start) begin
          start_cycles++;
          issue_cyc = cyc;
          if (core_en) begin
            pend    = 1'b1;
            cd      = core_lat;
            din_lat = bus.div_in;
            ans     = N'(one / {80'b0, bus.div_in});
          end
        end
      end
    end
  end

  // Result monitor: one line per completed transaction.
  initial forever begin
    exp_t         e;
    logic [N-2:0] diff;
    @(posedge clk);
    #1;
    if (bus.done === 1'b1) begin
      done_seen++;
      done_cyc = cyc;
      if (sb.size() == 0) begin
        chk_eq("spurious_done", 64'(bus.done), 64'd0);
      end else begin
        e = sb.pop_front();
        $display("[TB] %s quot=%h div0=%b tmo=%b", e.tag, bus.quot, bus.div0, bus.tmo);
        if (e.approx) begin
          diff = (bus.quot[N-2:0] > e.quot[N-2:0]) ? bus.quot[N-2:0] - e.quot[N-2:0]
                                                   : e.quot[N-2:0] - bus.quot[N-2:0];
          chk_eq({e.tag, "_sign"}, 64'(bus.quot[N-1]), 64'(e.quot[N-1]));
          chk_eq({e.tag, "_near"}, 64'(diff <= TOL), 64'd1);
        end else begin
          chk_eq({e.tag, "_quot"}, 64'(bus.quot), 64'(e.quot));
        end
        chk_eq({e.tag, "_div0"}, 64'(bus.div0), 64'(e.div0));
        chk_eq({e.tag, "_tmo"}, 64'(bus.tmo), 64'(e.tmo));
      end
    end
  end

  task automatic do_req(input logic [N-1:0] n, input logic [N-1:0] d,
                        input bit tmo_exp, input string tag);
    int guard;
    guard = 0;
    @(posedge clk);
    #2;
    while (bus.busy && guard < 400) begin
      @(posedge clk);
      #2;
      guard++;
    end
    if (guard >= 400) chk_eq({tag, "_idle_wait"}, 64'(bus.busy), 64'd0);
    sb.push_back(model(n, d, tmo_exp, tag));
    bus.start = 1'b1;
    bus.num   = n;
    bus.den   = d;
    @(posedge clk);
    #1;
    req_cyc   = cyc;
    bus.start = 1'b0;
  endtask

  task automatic drain(input string tag);
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 400) begin
      @(posedge clk);
      guard++;
    end
    #3;
    chk_eq({tag, "_drained"}, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int           d0;
    int           s0;
    int           guard;
    logic [N-1:0] rn;
    logic [N-1:0] rd;
    rst = 1'b0;
    bus.start = 1'b0;
    bus.num   = '0;
    bus.den   = '0;

    repeat (3) @(posedge clk);
    #1;
    chk_eq("rst_busy", 64'(bus.busy), 64'd0);
    chk_eq("rst_done", 64'(bus.done), 64'd0);
    chk_eq("rst_quot", 64'(bus.quot), 64'd0);
    chk_eq("rst_div0", 64'(bus.div0), 64'd0);
    chk_eq("rst_tmo", 64'(bus.tmo), 64'd0);
    chk_eq("rst_div_start", 64'(bus.div_start), 64'd0);
    chk_eq("rst_div_in", 64'(bus.div_in), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // 6.0 / 3.0
    s0 = start_cycles;
    do_req(48'h0006_0000_0000, 48'h0003_0000_0000, 1'b0, "t1_6div3");
    drain("t1");
    chk_eq("t1_div_start_cycles", 64'(start_cycles - s0), 64'd1);

    // -1.5 / 0.5 is exactly -3.0
    do_req(48'h8001_8000_0000, NUMBER_POINT_FIVE, 1'b0, "t2_neg");
    drain("t2");
    chk_eq("t2_exact", 64'(bus.quot), 64'h8003_0000_0000);

    // -2.0 / 0 saturates, core untouched, fixed latency
    s0 = start_cycles;
    do_req(NUMBER_TWO | 48'h8000_0000_0000, 48'h0000_0000_0000, 1'b0, "t3_div0");
    drain("t3");
    chk_eq("t3_latency", 64'(done_cyc - req_cyc), 64'd2);
    chk_eq("t3_no_div_start", 64'(start_cycles - s0), 64'd0);

    // 0 / -5.0 gives +0 without the core
    s0 = start_cycles;
    do_req(48'h0000_0000_0000, 48'h8005_0000_0000, 1'b0, "num0");
    drain("num0");
    chk_eq("num0_no_div_start", 64'(start_cycles - s0), 64'd0);

    // tiny negative / 1000.0 truncates to zero, which must come back as +0
    do_req(48'h8000_0000_0001, 48'h03E8_0000_0000, 1'b0, "pos_zero");
    drain("pos_zero");

    for (int i = 0; i < 4; i++) begin
      rn = {$urandom_range(1, 0), 15'($urandom_range(100, 1)), 32'($urandom)};
      rd = {$urandom_range(1, 0), 15'($urandom_range(50, 1)), 32'($urandom)};
      do_req(rn, rd, 1'b0, $sformatf("rand%0d", i));
      drain("rand");
    end

`ifdef FPDIV_TIMEOUT_EN
    core_en = 1'b0;
    do_req(NUMBER_ONE, 48'h0003_0000_0000, 1'b1, "tmo");
    drain("tmo");
    chk_eq("tmo_latency", 64'(done_cyc - issue_cyc), 64'd18);
    core_en = 1'b1;
    do_req(NUMBER_ONE, NUMBER_TWO, 1'b0, "after_tmo");
    drain("after_tmo");
`endif

    // reset while waiting on the core: no result, then a clean 1.0/4.0
    core_lat = 20;
    d0 = done_seen;
    do_req(NUMBER_ONE, 48'h0003_0000_0000, 1'b0, "t5_aborted");
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    void'(sb.pop_back());
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_eq("t5_busy_after_rst", 64'(bus.busy), 64'd0);
    chk_eq("t5_done_after_rst", 64'(bus.done), 64'd0);
    chk_eq("t5_no_done", 64'(done_seen - d0), 64'd0);
    core_lat = 3;
    do_req(NUMBER_ONE, 48'h0004_0000_0000, 1'b0, "t5_quarter");
    drain("t5");

    // start in the done clock is accepted; a start while busy is dropped
    core_lat = 2;
    d0 = done_seen;
    do_req(NUMBER_ONE, NUMBER_TWO, 1'b0, "t6_half");
    guard = 0;
    @(posedge clk);
    #2;
    while (bus.done !== 1'b1 && guard < 200) begin
      @(posedge clk);
      #2;
      guard++;
    end
    chk_eq("t6_done_seen", 64'(bus.done), 64'd1);
    sb.push_back(model(NUMBER_ONE, 48'h0008_0000_0000, 1'b0, "t6_eighth"));
    bus.start = 1'b1;
    bus.num   = NUMBER_ONE;
    bus.den   = 48'h0008_0000_0000;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_eq("t6_busy", 64'(bus.busy), 64'd1);
    bus.start = 1'b1;
    bus.num   = 48'h0005_0000_0000;
    bus.den   = NUMBER_ONE;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    drain("t6");
    repeat (20) @(posedge clk);
    #2;
    chk_eq("t6_done_count", 64'(done_seen - d0), 64'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
